// File: rtl/wbu_stage.sv
// Write-back stage: accepts one instruction per valid/ready handshake, waits for
// load data when needed, holds next PC and write-back data until the IFU commits.
module wbu_stage #(
  parameter int XLEN   = 32,
  parameter int NR_REG = 16,
  parameter int REG_AW = $clog2(NR_REG),
  parameter int CNT_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_wb_sel,
  input  logic [1:0]        in_pc_sel,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [XLEN-1:0]   in_result,
  input  logic [XLEN-1:0]   in_snpc,
  input  logic [XLEN-1:0]   in_csr_rdata,
  input  logic [XLEN-1:0]   in_mtvec,
  input  logic [XLEN-1:0]   in_mepc,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_dnpc,
  output logic              rf_wen,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic [CNT_W-1:0]  retire_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT_MEM, HOLD} state_t;

  localparam logic [2:0] SEL_NONE = 3'd0;
  localparam logic [2:0] SEL_ALU  = 3'd1;
  localparam logic [2:0] SEL_MEM  = 3'd2;
  localparam logic [2:0] SEL_LINK = 3'd3;
  localparam logic [2:0] SEL_CSR  = 3'd4;

  localparam logic [1:0] PC_SNPC   = 2'd0;
  localparam logic [1:0] PC_RESULT = 2'd1;
  localparam logic [1:0] PC_MTVEC  = 2'd2;

  state_t            state_q, state_d;
  logic [2:0]        wb_sel_q;
  logic [REG_AW-1:0] waddr_q;
  logic [XLEN-1:0]   dnpc_q, dnpc_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              accept, commit, writes_q;

  assign in_ready = (state_q == IDLE) || (state_q == HOLD && out_ready);
  assign accept   = in_valid && in_ready;
  assign out_valid = (state_q == HOLD);
  assign commit   = out_valid && out_ready;

  // Codes 5-7 are illegal and behave like NONE; x0 writes are dropped.
  assign writes_q = (wb_sel_q inside {SEL_ALU, SEL_MEM, SEL_LINK, SEL_CSR}) &&
                    (waddr_q != '0);
  assign rf_wen   = commit && writes_q;

  assign out_dnpc   = dnpc_q;
  assign rf_waddr   = waddr_q;
  assign rf_wdata   = wdata_q;
  assign retire_cnt = cnt_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    dnpc_d = in_snpc;
    case (in_pc_sel)
      PC_SNPC:   dnpc_d = in_snpc;
      PC_RESULT: dnpc_d = in_result;
      PC_MTVEC:  dnpc_d = in_mtvec;
      default:   dnpc_d = in_mepc;
    endcase
  end

  always_comb begin
    wdata_d = '0;
    case (in_wb_sel)
      SEL_ALU:  wdata_d = in_result;
      SEL_LINK: wdata_d = in_snpc;
      SEL_CSR:  wdata_d = in_csr_rdata;
      default:  wdata_d = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (accept) state_d = (in_wb_sel == SEL_MEM) ? WAIT_MEM : HOLD;
      WAIT_MEM: if (mem_rvalid) state_d = HOLD;
      HOLD: begin
        if (commit) begin
          if (accept) state_d = (in_wb_sel == SEL_MEM) ? WAIT_MEM : HOLD;
          else        state_d = IDLE;
        end
      end
      default:  state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wb_sel_q <= SEL_NONE;
      waddr_q  <= '0;
      dnpc_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        wb_sel_q <= in_wb_sel;
        waddr_q  <= in_rd;
        dnpc_q   <= dnpc_d;
        if (in_wb_sel != SEL_MEM) wdata_q <= wdata_d;
      end else if (state_q == WAIT_MEM && mem_rvalid) begin
        wdata_q <= mem_rdata;
      end
      if (commit) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_wbu_stage.sv
// Directed bench for wbu_stage: a scoreboard of expected commits is filled as
// instructions are driven and drained by a monitor on each commit.
module tb_wbu_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready, mem_rvalid;
  logic [2:0]  in_wb_sel;
  logic [1:0]  in_pc_sel;
  logic [3:0]  in_rd;
  logic [31:0] in_result, in_snpc, in_csr_rdata, in_mtvec, in_mepc, mem_rdata;

  logic        in_ready, out_valid, rf_wen;
  logic [31:0] out_dnpc, rf_wdata;
  logic [3:0]  rf_waddr;
  logic [63:0] retire_cnt;

  logic        in_ready4, out_valid4, rf_wen4;
  logic [31:0] out_dnpc4, rf_wdata4;
  logic [3:0]  rf_waddr4;
  logic [3:0]  retire_cnt4;

  wbu_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_wb_sel(in_wb_sel), .in_pc_sel(in_pc_sel), .in_rd(in_rd),
    .in_result(in_result), .in_snpc(in_snpc), .in_csr_rdata(in_csr_rdata),
    .in_mtvec(in_mtvec), .in_mepc(in_mepc), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_dnpc(out_dnpc), .rf_wen(rf_wen), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .retire_cnt(retire_cnt)
  );

  wbu_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .in_wb_sel(in_wb_sel), .in_pc_sel(in_pc_sel), .in_rd(in_rd),
    .in_result(in_result), .in_snpc(in_snpc), .in_csr_rdata(in_csr_rdata),
    .in_mtvec(in_mtvec), .in_mepc(in_mepc), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .out_valid(out_valid4), .out_ready(out_ready),
    .out_dnpc(out_dnpc4), .rf_wen(rf_wen4), .rf_waddr(rf_waddr4),
    .rf_wdata(rf_wdata4), .retire_cnt(retire_cnt4)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] dnpc;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic        wen;
  } exp_t;

  exp_t sb[$];
  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Drives one instruction (from posedge+1), queues its expected commit, and
  // returns just after the edge that accepted it with in_valid still high.
  task automatic send(input logic [2:0] ws, input logic [1:0] ps, input logic [3:0] rd,
                      input logic [31:0] res, input logic [31:0] snpc,
                      input logic [31:0] csr, input logic [31:0] mtvec,
                      input logic [31:0] mepc, input logic [31:0] memd);
    exp_t e;
    bit   ok = 0;
    in_valid = 1'b1; in_wb_sel = ws; in_pc_sel = ps; in_rd = rd;
    in_result = res; in_snpc = snpc; in_csr_rdata = csr; in_mtvec = mtvec; in_mepc = mepc;
    case (ps)
      2'd0: e.dnpc = snpc;
      2'd1: e.dnpc = res;
      2'd2: e.dnpc = mtvec;
      default: e.dnpc = mepc;
    endcase
    case (ws)
      3'd1: e.wdata = res;
      3'd2: e.wdata = memd;
      3'd3: e.wdata = snpc;
      3'd4: e.wdata = csr;
      default: e.wdata = 32'h0;
    endcase
    e.waddr = rd;
    e.wen   = (ws >= 3'd1 && ws <= 3'd4) && (rd != 4'd0);
    sb.push_back(e);
    for (int i = 0; i < 20; i++) begin
      sample();
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) check("accept_timeout", 64'd0, 64'd1);
    tick();
  endtask

  // Commit monitor: compares each retiring instruction with the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_empty_on_commit", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("commit_dnpc",  64'(out_dnpc), 64'(e.dnpc));
          check("commit_waddr", 64'(rf_waddr), 64'(e.waddr));
          check("commit_wdata", 64'(rf_wdata), 64'(e.wdata));
          check("commit_wen",   64'(rf_wen),   64'(e.wen));
        end
      end else if (out_valid) begin
        check("stall_no_wen", 64'(rf_wen), 64'd0);
      end
    end
  end

  initial begin
    int start;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mem_rvalid = 1'b0;
    in_wb_sel = '0; in_pc_sel = '0; in_rd = '0; in_result = '0; in_snpc = '0;
    in_csr_rdata = '0; in_mtvec = '0; in_mepc = '0; mem_rdata = '0;
    repeat (2) tick();
    rst = 1'b0;

    // Reset values
    sample();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_rf_wen", 64'(rf_wen), 64'd0);
    check("rst_dnpc", 64'(out_dnpc), 64'd0);
    check("rst_waddr", 64'(rf_waddr), 64'd0);
    check("rst_wdata", 64'(rf_wdata), 64'd0);
    check("rst_retire", retire_cnt, 64'd0);
    tick();

    // ALU instruction, held one cycle before commit
    send(3'd1, 2'd0, 4'd5, 32'h1234, 32'h8000_0004, 0, 0, 0, 0);
    in_valid = 1'b0;
    sample();
    check("alu_out_valid", 64'(out_valid), 64'd1);
    check("alu_dnpc", 64'(out_dnpc), 64'h8000_0004);
    tick();
    out_ready = 1'b1;
    sample();
    tick();
    sample();
    check("alu_retire", retire_cnt, 64'd1);
    tick();

    // Load waiting three cycles for data
    send(3'd2, 2'd0, 4'd3, 32'h0, 32'h8000_0010, 0, 0, 0, 32'hDEAD_BEEF);
    in_valid = 1'b0;
    repeat (3) begin
      sample();
      check("ld_wait_in_ready", 64'(in_ready), 64'd0);
      check("ld_wait_out_valid", 64'(out_valid), 64'd0);
      tick();
    end
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    sample();
    check("ld_out_valid", 64'(out_valid), 64'd1);
    tick();
    sample();
    check("ld_retire", retire_cnt, 64'd2);
    tick();

    // Backpressure: outputs held stable, nothing written
    out_ready = 1'b0;
    send(3'd1, 2'd1, 4'd7, 32'h55AA_0000, 32'h8000_0020, 0, 0, 0, 0);
    in_valid = 1'b0;
    repeat (4) begin
      sample();
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_dnpc", 64'(out_dnpc), 64'h55AA_0000);
      check("bp_waddr", 64'(rf_waddr), 64'd7);
      check("bp_wdata", 64'(rf_wdata), 64'h55AA_0000);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      tick();
    end

    // Stream 8 ALU instructions at full rate
    out_ready = 1'b1;
    start = cyc;
    for (int i = 0; i < 8; i++)
      send(3'd1, 2'd0, 4'(i + 8), 32'h100 + 32'(i), 32'h8000_0200 + 32'(4 * i), 0, 0, 0, 0);
    in_valid = 1'b0;
    check("stream_cycles", 64'(cyc - start), 64'd8);
    sample();
    tick();
    sample();
    check("stream_retire", retire_cnt, 64'd11);
    tick();

    // jal, ecall, mret, rd=0 and illegal wb_sel, back to back
    send(3'd3, 2'd1, 4'd1, 32'h8000_0100, 32'h8000_0008, 0, 0, 0, 0);
    send(3'd0, 2'd2, 4'd2, 32'h0, 32'h8000_0030, 0, 32'h8000_1000, 0, 0);
    send(3'd0, 2'd3, 4'd6, 32'h0, 32'h8000_0034, 0, 32'h8000_1000, 32'h8000_0ABC, 0);
    send(3'd1, 2'd0, 4'd0, 32'h77, 32'h8000_0038, 0, 0, 0, 0);
    send(3'd6, 2'd0, 4'd4, 32'h99, 32'h8000_003C, 32'h5, 0, 0, 0);
    in_valid = 1'b0;
    sample();
    tick();
    sample();
    check("ctrl_retire", retire_cnt, 64'd16);
    tick();

    // Reset while waiting for load data discards the instruction
    send(3'd2, 2'd0, 4'd9, 32'h0, 32'h8000_0040, 0, 0, 0, 32'h1234_5678);
    in_valid = 1'b0;
    sample();
    check("rstwm_in_ready", 64'(in_ready), 64'd0);
    tick();
    rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_rvalid = 1'b0;
    repeat (3) begin
      sample();
      check("rstwm_out_valid", 64'(out_valid), 64'd0);
      check("rstwm_rf_wen", 64'(rf_wen), 64'd0);
      check("rstwm_retire", retire_cnt, 64'd0);
      tick();
    end

    // 17 retirements: 64-bit counter reads 17, 4-bit counter wraps to 1
    for (int i = 0; i < 17; i++)
      send(3'd1, 2'd0, 4'(i % 15 + 1), 32'(i), 32'h8000_1000 + 32'(4 * i), 0, 0, 0, 0);
    in_valid = 1'b0;
    sample();
    tick();
    sample();
    check("wrap_retire64", retire_cnt, 64'd17);
    check("wrap_retire4", 64'(retire_cnt4), 64'd1);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
